down_counter_timer: RTL

- Synchronous, loadable down counter. It is the count-down counterpart of the team's T-flip-flop ripple up counter.
- Loads a reload value, decrements on qualified tick pulses, and emits a one-cycle done pulse at terminal count. Optionally auto-reloads.
- Used in the keypad-scanner family for scan dwell timing and debounce intervals.
- Fully synchronous to one clock. There is no ripple clocking.

---
 rtl/down_counter_timer_pkg.sv | 15 +
 rtl/tick_prescaler.sv | 32 +++
 rtl/down_counter_timer.sv | 110 +++++++++++
 3 files changed

// File: rtl/down_counter_timer_pkg.sv
// Shared encodings and defaults for the loadable down counter timer.
// The optional prescaler is enabled by DOWN_COUNTER_TIMER_PRESCALE_EN.
package down_counter_timer_pkg;

  localparam int unsigned DEFAULT_SIZE     = 8;
  localparam int unsigned DEFAULT_PRESCALE = 4;
  localparam string       PRESCALE_MACRO   = "DOWN_COUNTER_TIMER_PRESCALE_EN";

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_e;

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk into one count-enable pulse every PRESCALE cycles while enabled.
module tick_prescaler
  import down_counter_timer_pkg::*;
#(
  parameter int unsigned PRESCALE = DEFAULT_PRESCALE
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic tick_out
);

  localparam int unsigned CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [CW-1:0] cnt;

  // Pulse on the last phase so the first pulse lands PRESCALE cycles after enable.
  assign tick_out = enable && (cnt == CW'(PRESCALE - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      if (tick_out) cnt <= '0;
      else          cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/down_counter_timer.sv
// Loadable down counter with done pulse at terminal count and optional auto-reload.
// Define DOWN_COUNTER_TIMER_PRESCALE_EN to count internal prescaler pulses instead of tick.
module down_counter_timer
  import down_counter_timer_pkg::*;
#(
  parameter int unsigned SIZE = DEFAULT_SIZE
`ifdef DOWN_COUNTER_TIMER_PRESCALE_EN
  ,
  parameter int unsigned PRESCALE = DEFAULT_PRESCALE
`endif
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic [SIZE-1:0] load_value,
  input  logic            start,
  input  logic            stop,
  input  logic            auto_reload,
  input  logic            tick,
  output logic [SIZE-1:0] value,
  output logic            busy,
  output logic            done
);

  state_e          state;
  logic [SIZE-1:0] reload;
  logic            cnt_en_c;
  logic            start_idle_c;
  logic            terminal_c;

  // Start from IDLE only when there is something to count.
  assign start_idle_c = (state == ST_IDLE) && !load && start &&
                        ((value != '0) || (reload != '0));
  assign terminal_c   = (state == ST_RUN) && !load && !stop && cnt_en_c &&
                        (value == SIZE'(1));

`ifdef DOWN_COUNTER_TIMER_PRESCALE_EN
  logic unused_tick;
  assign unused_tick = tick;

  tick_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (load || start_idle_c || terminal_c),
    .enable   (state == ST_RUN),
    .tick_out (cnt_en_c)
  );
`else
  assign cnt_en_c = tick;
`endif

  // Control FSM; priority is load > stop > start > count enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      value  <= '0;
      reload <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load) begin
        value  <= load_value;
        reload <= load_value;
        state  <= ST_IDLE;
        busy   <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start_idle_c) begin
              state <= ST_RUN;
              busy  <= 1'b1;
              if (value == '0) value <= reload;
            end
          end
          ST_PAUSE: begin
            if (start) begin
              state <= ST_RUN;
              busy  <= 1'b1;
            end
          end
          ST_RUN: begin
            if (stop) begin
              state <= ST_PAUSE;
              busy  <= 1'b0;
            end else if (terminal_c) begin
              done <= 1'b1;
              if (auto_reload && (reload != '0)) begin
                value <= reload;
              end else begin
                value <= '0;
                state <= ST_IDLE;
                busy  <= 1'b0;
              end
            end else if (cnt_en_c && (value > SIZE'(1))) begin
              value <= value - SIZE'(1);
            end
          end
          default: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
